// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for the Mini SRC datapath.
// Ports:
//   clk, reset (async, active-low)   - clock and reset
//   IR[31:0], CON_FF                 - opcode source (IR[31:27]) and branch condition
//   bus enables, register-file selects, register loads, ALU selects,
//   memory strobes, CON_RESET, run   - control outputs, decoded from the state
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        INout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        HIin,
    output logic        LOin,
    output logic        PCin,
    output logic        IRin,
    output logic        Zin,
    output logic        Yin,
    output logic        MARin,
    output logic        MDRin,
    output logic        CONin,
    output logic        OUT_Portin,
    output logic        IncPC,
    output logic        PCSave,
    output logic        AND,
    output logic        OR,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        Read,
    output logic        read_mem,
    output logic        write_mem,
    output logic        CON_RESET,
    output logic        run
);

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    state_e          state_q;
    state_e          state_d;
    state_e          last_step;
    logic            exec;
    logic [OP_W-1:0] opcode;
    logic            unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_RST;
        else        state_q <= state_d;
    end

    // Next state: advance one step per clock until the opcode's final step
    always_comb begin
        state_d   = state_q;
        last_step = S_T3;
        case (opcode)
            OP_LD, OP_ST:                          last_step = S_T7;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI:              last_step = S_T5;
            OP_DIV, OP_MUL, OP_BR:                 last_step = S_T6;
            OP_NEG, OP_NOT, OP_JAL:                last_step = S_T4;
            default:                               last_step = S_T3;
        endcase
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_q == last_step) state_d = (opcode == OP_HALT) ? S_HALT : S_T0;
                else                      state_d = state_e'(4'(state_q) + 4'd1);
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Output decode from state, opcode and (branch T6) CON_FF
    always_comb begin
        HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; INout = 1'b0; Cout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; IRin = 1'b0; Zin = 1'b0;
        Yin = 1'b0; MARin = 1'b0; MDRin = 1'b0; CONin = 1'b0; OUT_Portin = 1'b0;
        IncPC = 1'b0; PCSave = 1'b0;
        AND = 1'b0; OR = 1'b0; ADD = 1'b0; SUB = 1'b0; MUL = 1'b0; DIV = 1'b0;
        SHR = 1'b0; SHRA = 1'b0; SHL = 1'b0; ROR = 1'b0; ROL = 1'b0; NEG = 1'b0; NOT = 1'b0;
        Read = 1'b0; read_mem = 1'b0; write_mem = 1'b0;
        CON_RESET = 1'b0;
        run  = (state_q != S_HALT);
        exec = (state_q inside {S_T3, S_T4, S_T5, S_T6, S_T7});

        case (state_q)
            S_RST: CON_RESET = 1'b1;
            S_T0:  begin IncPC = 1'b1; MARin = 1'b1; PCin = 1'b1; end
            S_T1:  begin read_mem = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2:  begin MDRout = 1'b1; IRin = 1'b1; end
            default: ;
        endcase

        if (exec) begin
            case (opcode)
                // Memory group shares the base+offset address computation
                OP_LD, OP_LDI, OP_ST: begin
                    case (state_q)
                        S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                        S_T4: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                        S_T5: begin
                            Zlowout = 1'b1;
                            if (opcode == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                            else MARin = 1'b1;
                        end
                        S_T6: begin
                            MDRin = 1'b1;
                            if (opcode == OP_LD) begin read_mem = 1'b1; Read = 1'b1; end
                            else begin Gra = 1'b1; Rout = 1'b1; end
                        end
                        S_T7: begin
                            if (opcode == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            else write_mem = 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Register and immediate ALU ops differ only in the T4 B operand
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    case (state_q)
                        S_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        S_T4: begin
                            Zin = 1'b1;
                            if (opcode inside {OP_ADDI, OP_ANDI, OP_ORI}) Cout = 1'b1;
                            else begin Grc = 1'b1; Rout = 1'b1; end
                            case (opcode)
                                OP_ADD, OP_ADDI: ADD  = 1'b1;
                                OP_SUB:          SUB  = 1'b1;
                                OP_AND, OP_ANDI: AND  = 1'b1;
                                OP_OR, OP_ORI:   OR   = 1'b1;
                                OP_ROR:          ROR  = 1'b1;
                                OP_ROL:          ROL  = 1'b1;
                                OP_SHR:          SHR  = 1'b1;
                                OP_SHRA:         SHRA = 1'b1;
                                OP_SHL:          SHL  = 1'b1;
                                default: ;
                            endcase
                        end
                        S_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
                // 64-bit result: low half to LO, then high half to HI
                OP_DIV, OP_MUL: begin
                    case (state_q)
                        S_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        S_T4: begin
                            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                            DIV = (opcode == OP_DIV);
                            MUL = (opcode == OP_MUL);
                        end
                        S_T5: begin Zlowout = 1'b1; LOin = 1'b1; end
                        S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                        default: ;
                    endcase
                end
                OP_NEG, OP_NOT: begin
                    case (state_q)
                        S_T3: begin
                            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                            NEG = (opcode == OP_NEG);
                            NOT = (opcode == OP_NOT);
                        end
                        S_T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
                // Target is always computed; CON_FF only gates the PC load
                OP_BR: begin
                    case (state_q)
                        S_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                        S_T4: begin PCout = 1'b1; Yin = 1'b1; end
                        S_T5: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                        S_T6: begin Zlowout = 1'b1; PCin = CON_FF; end
                        default: ;
                    endcase
                end
                OP_JAL: begin
                    case (state_q)
                        S_T3: PCSave = 1'b1;
                        S_T4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        default: ;
                    endcase
                end
                OP_JR:   if (state_q == S_T3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                OP_IN:   if (state_q == S_T3) begin INout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_OUT:  if (state_q == S_T3) begin Gra = 1'b1; Rout = 1'b1; OUT_Portin = 1'b1; end
                OP_MFLO: if (state_q == S_T3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_MFHI: if (state_q == S_T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed stimulus with a scoreboard queue of expected control vectors.
// Stimulus pushes the hand-computed vector for each cycle; a monitor pops and compares
// at the falling edge, or immediately when an asynchronous event is being checked.
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] IR;
    logic        CON_FF;

    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
    logic IncPC, PCSave;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic Read, read_mem, write_mem, CON_RESET, run;

    control_unit dut (
        .clk(clk), .reset(reset), .IR(IR), .CON_FF(CON_FF),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout), .INout(INout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
        .MARin(MARin), .MDRin(MDRin), .CONin(CONin), .OUT_Portin(OUT_Portin),
        .IncPC(IncPC), .PCSave(PCSave),
        .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
        .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .Read(Read), .read_mem(read_mem), .write_mem(write_mem),
        .CON_RESET(CON_RESET), .run(run)
    );

    logic [43:0] act;
    assign act = {run, CON_RESET, write_mem, read_mem, Read,
                  NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND,
                  PCSave, IncPC,
                  OUT_Portin, CONin, MDRin, MARin, Yin, Zin, IRin, PCin, LOin, HIin,
                  BAout, Rout, Rin, Grc, Grb, Gra,
                  Cout, INout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout};

    localparam logic [43:0] M_HIOUT    = 44'h1 << 0;
    localparam logic [43:0] M_LOOUT    = 44'h1 << 1;
    localparam logic [43:0] M_ZHIGHOUT = 44'h1 << 2;
    localparam logic [43:0] M_ZLOWOUT  = 44'h1 << 3;
    localparam logic [43:0] M_PCOUT    = 44'h1 << 4;
    localparam logic [43:0] M_MDROUT   = 44'h1 << 5;
    localparam logic [43:0] M_COUT     = 44'h1 << 7;
    localparam logic [43:0] M_GRA      = 44'h1 << 8;
    localparam logic [43:0] M_GRB      = 44'h1 << 9;
    localparam logic [43:0] M_GRC      = 44'h1 << 10;
    localparam logic [43:0] M_RIN      = 44'h1 << 11;
    localparam logic [43:0] M_ROUT     = 44'h1 << 12;
    localparam logic [43:0] M_BAOUT    = 44'h1 << 13;
    localparam logic [43:0] M_HIIN     = 44'h1 << 14;
    localparam logic [43:0] M_LOIN     = 44'h1 << 15;
    localparam logic [43:0] M_PCIN     = 44'h1 << 16;
    localparam logic [43:0] M_IRIN     = 44'h1 << 17;
    localparam logic [43:0] M_ZIN      = 44'h1 << 18;
    localparam logic [43:0] M_YIN      = 44'h1 << 19;
    localparam logic [43:0] M_MARIN    = 44'h1 << 20;
    localparam logic [43:0] M_MDRIN    = 44'h1 << 21;
    localparam logic [43:0] M_CONIN    = 44'h1 << 22;
    localparam logic [43:0] M_INCPC    = 44'h1 << 24;
    localparam logic [43:0] M_ADD      = 44'h1 << 28;
    localparam logic [43:0] M_MUL      = 44'h1 << 30;
    localparam logic [43:0] M_NEG      = 44'h1 << 37;
    localparam logic [43:0] M_READ     = 44'h1 << 39;
    localparam logic [43:0] M_RDMEM    = 44'h1 << 40;
    localparam logic [43:0] M_WRMEM    = 44'h1 << 41;
    localparam logic [43:0] M_CONRST   = 44'h1 << 42;
    localparam logic [43:0] M_RUN      = 44'h1 << 43;

    localparam logic [43:0] V_RST = M_RUN | M_CONRST;
    localparam logic [43:0] V_T0  = M_RUN | M_INCPC | M_MARIN | M_PCIN;
    localparam logic [43:0] V_T1  = M_RUN | M_RDMEM | M_READ | M_MDRIN;
    localparam logic [43:0] V_T2  = M_RUN | M_MDROUT | M_IRIN;

    localparam logic [31:0] IR_LD   = 32'h0000_0000;
    localparam logic [31:0] IR_ST   = 32'h1080_0067;
    localparam logic [31:0] IR_ADD  = 32'h1889_8000;
    localparam logic [31:0] IR_MUL  = 32'h8080_0000;
    localparam logic [31:0] IR_NEG  = 32'h8800_0000;
    localparam logic [31:0] IR_BR   = 32'h9880_0000;
    localparam logic [31:0] IR_JR   = 32'hA800_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_RSVD = 32'hF800_0000;

    typedef struct {
        logic [43:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    bit   samp_tgl;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one pop per falling edge (or forced sample), full-vector compare plus invariants
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or samp_tgl);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: actual=%h required=%h", e.name, act, e.exp);
                end
                n_checks++;
                if ($countones(act[38:26]) > 1 || (read_mem && write_mem)) begin
                    n_fail++;
                    $display("FAIL %s_excl: actual alu/mem bits=%b required at most one alu, no rd+wr",
                             e.name, act[41:26]);
                end
            end
        end
    end

    task automatic cyc(input logic [43:0] e, input string nm);
        @(posedge clk);
        #1;
        exp_q.push_back('{exp: e, name: nm});
    endtask

    task automatic cyc_rst(input logic r, input logic [43:0] e, input string nm);
        @(posedge clk);
        #1;
        reset = r;
        exp_q.push_back('{exp: e, name: nm});
    endtask

    // Three fetch cycles; the next instruction word appears in IR during T2
    task automatic fetch(input logic [31:0] ir_next, input string nm);
        cyc(V_T0, {nm, "_t0"});
        cyc(V_T1, {nm, "_t1"});
        cyc(V_T2, {nm, "_t2"});
        IR = ir_next;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        samp_tgl = 1'b0;
        reset    = 1'b1;
        IR       = IR_ST;
        CON_FF   = 1'b0;
        #2 reset = 1'b0;

        cyc(V_RST, "rst_low0");
        cyc(V_RST, "rst_low1");
        cyc_rst(1'b1, V_RST, "rst_release");

        fetch(IR_ST, "st");
        cyc(M_RUN | M_GRB | M_BAOUT | M_YIN,  "st_t3");
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN,   "st_t4");
        cyc(M_RUN | M_ZLOWOUT | M_MARIN,      "st_t5");
        cyc(M_RUN | M_GRA | M_ROUT | M_MDRIN, "st_t6");
        cyc(M_RUN | M_WRMEM,                  "st_t7");

        fetch(IR_ADD, "add");
        cyc(M_RUN | M_GRB | M_ROUT | M_YIN,           "add_t3");
        cyc(M_RUN | M_GRC | M_ROUT | M_ADD | M_ZIN,   "add_t4");
        cyc(M_RUN | M_ZLOWOUT | M_GRA | M_RIN,        "add_t5");

        fetch(IR_MUL, "mul");
        cyc(M_RUN | M_GRA | M_ROUT | M_YIN,           "mul_t3");
        cyc(M_RUN | M_GRB | M_ROUT | M_MUL | M_ZIN,   "mul_t4");
        cyc(M_RUN | M_ZLOWOUT | M_LOIN,               "mul_t5");
        cyc(M_RUN | M_ZHIGHOUT | M_HIIN,              "mul_t6");

        CON_FF = 1'b1;
        fetch(IR_BR, "br1");
        cyc(M_RUN | M_GRA | M_ROUT | M_CONIN, "br1_t3");
        cyc(M_RUN | M_PCOUT | M_YIN,          "br1_t4");
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN,   "br1_t5");
        cyc(M_RUN | M_ZLOWOUT | M_PCIN,       "br1_t6");

        fetch(IR_BR, "br0");
        CON_FF = 1'b0;
        cyc(M_RUN | M_GRA | M_ROUT | M_CONIN, "br0_t3");
        cyc(M_RUN | M_PCOUT | M_YIN,          "br0_t4");
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN,   "br0_t5");
        cyc(M_RUN | M_ZLOWOUT,                "br0_t6");

        fetch(IR_NEG, "neg");
        cyc(M_RUN | M_GRB | M_ROUT | M_NEG | M_ZIN, "neg_t3");
        cyc(M_RUN | M_ZLOWOUT | M_GRA | M_RIN,      "neg_t4");

        fetch(IR_JR, "jr");
        cyc(M_RUN | M_GRA | M_ROUT | M_PCIN, "jr_t3");

        fetch(IR_RSVD, "rsvd");
        cyc(M_RUN, "rsvd_t3");

        fetch(IR_HALT, "halt");
        cyc(M_RUN, "halt_t3");
        for (int i = 0; i < 10; i++) cyc(44'h0, "halt_idle");
        cyc_rst(1'b0, V_RST, "halt_rst_low");
        cyc_rst(1'b1, V_RST, "halt_rst_rel");

        fetch(IR_LD, "ld");
        cyc(M_RUN | M_GRB | M_BAOUT | M_YIN, "ld_t3");
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN,  "ld_t4");
        cyc(M_RUN | M_ZLOWOUT | M_MARIN,     "ld_t5");
        // Drop reset mid-cycle and sample before any clock edge
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back('{exp: V_RST, name: "async_drop"});
        samp_tgl = ~samp_tgl;
        cyc_rst(1'b0, V_RST, "async_held");
        cyc_rst(1'b1, V_RST, "async_release");
        cyc(V_T0, "post_t0");
        cyc(V_T1, "post_t1");

        @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
